// File: rtl/bnn_pkg.sv
// Shared defaults, score type and FSM states for the streaming BNN classifier.
package bnn_pkg;
    localparam int DEF_IMG_W     = 28;
    localparam int DEF_IMG_H     = 28;
    localparam int DEF_N_CLASSES = 10;
    localparam int DEF_SCORE_W   = $clog2(DEF_IMG_W*DEF_IMG_H+1);

    typedef logic [DEF_SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ARGMAX,
        DONE
    } state_t;
endpackage

// File: rtl/bnn_xnor_popcount.sv
// Counts matching pixels between one image row and one weight row.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int CNT_W = $clog2(IMG_W+1)
) (
    input  logic [IMG_W-1:0] i_row,
    input  logic [IMG_W-1:0] i_weight,
    output logic [CNT_W-1:0] o_count
);
    logic [IMG_W-1:0] w_match;

    assign w_match = ~(i_row ^ i_weight);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < IMG_W; i++) begin
            o_count = o_count + CNT_W'(w_match[i]);
        end
    end
endmodule

// File: rtl/bnn_stream_classifier.sv
// Row-streaming binary classifier: accumulates XNOR-popcount scores per class, then resolves argmax.
module bnn_stream_classifier
    import bnn_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int N_CLASSES = DEF_N_CLASSES,
    parameter int SCORE_W   = $clog2(IMG_W*IMG_H+1),
    parameter int CLS_W     = $clog2(N_CLASSES)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [IMG_W-1:0]             row_i,
    input  logic                         row_valid_i,
    output logic                         row_ready_o,
    input  logic                         wt_we_i,
    input  logic [CLS_W-1:0]             wt_class_i,
    input  logic [$clog2(IMG_H)-1:0]     wt_row_i,
    input  logic [IMG_W-1:0]             wt_data_i,
    output logic                         wt_ready_o,
    output logic [N_CLASSES*SCORE_W-1:0] score_o,
    output logic [CLS_W-1:0]             class_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int CNT_W = $clog2(IMG_W+1);

    state_t             r_state;
    state_t             w_nextState;
    logic [ROW_W-1:0]   r_rowCnt;
    logic [CLS_W-1:0]   r_clsCnt;
    logic [IMG_W-1:0]   r_row;
    logic [SCORE_W-1:0] r_acc [N_CLASSES];
    logic [SCORE_W-1:0] r_best;
    logic [CLS_W-1:0]   r_bestIdx;
    logic [IMG_W-1:0]   r_wt [N_CLASSES][IMG_H];
    logic [IMG_W-1:0]   w_weight;
    logic [CNT_W-1:0]   w_pop;
    logic               w_lastCls;
    logic               w_lastRow;
    logic               w_rowFire;
    logic               w_wtFire;

    assign w_lastCls = (r_clsCnt == CLS_W'(N_CLASSES-1));
    assign w_lastRow = (r_rowCnt == ROW_W'(IMG_H-1));
    assign w_rowFire = row_valid_i && row_ready_o;
    assign w_wtFire  = wt_we_i && wt_ready_o
                       && (int'(wt_class_i) < N_CLASSES) && (int'(wt_row_i) < IMG_H);
    assign w_weight  = r_wt[r_clsCnt][r_rowCnt];
    assign class_o   = r_bestIdx;

    bnn_xnor_popcount #(
        .IMG_W (IMG_W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .i_row    (r_row),
        .i_weight (w_weight),
        .o_count  (w_pop)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_rowFire)   w_nextState = ACCUM;
            ACCUM:   if (w_lastCls)   w_nextState = w_lastRow ? ARGMAX : IDLE;
            ARGMAX:  if (w_lastCls)   w_nextState = DONE;
            DONE:    if (res_ready_i) w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
    end

    always_comb begin
        row_ready_o = 1'b0;
        wt_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                row_ready_o = 1'b1;
                wt_ready_o  = (r_rowCnt == '0);
            end
            DONE:    res_valid_o = 1'b1;
            default: ;
        endcase
    end

    // The class counter is shared by the accumulate pass and the argmax scan.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rowCnt  <= '0;
            r_clsCnt  <= '0;
            r_row     <= '0;
            r_best    <= '0;
            r_bestIdx <= '0;
            for (int c = 0; c < N_CLASSES; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rowFire) begin
                        r_row    <= row_i;
                        r_clsCnt <= '0;
                    end
                end
                ACCUM: begin
                    r_acc[r_clsCnt] <= r_acc[r_clsCnt] + SCORE_W'(w_pop);
                    if (w_lastCls) begin
                        r_clsCnt <= '0;
                        if (w_lastRow) begin
                            r_rowCnt  <= '0;
                            r_best    <= '0;
                            r_bestIdx <= '0;
                        end else begin
                            r_rowCnt <= r_rowCnt + ROW_W'(1);
                        end
                    end else begin
                        r_clsCnt <= r_clsCnt + CLS_W'(1);
                    end
                end
                ARGMAX: begin
                    // Strict compare keeps the lowest index on ties.
                    if (r_acc[r_clsCnt] > r_best) begin
                        r_best    <= r_acc[r_clsCnt];
                        r_bestIdx <= r_clsCnt;
                    end
                    if (w_lastCls) begin
                        r_clsCnt <= '0;
                    end else begin
                        r_clsCnt <= r_clsCnt + CLS_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        for (int c = 0; c < N_CLASSES; c++) begin
                            r_acc[c] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Weights survive reset so a source only has to load them once.
    always_ff @(posedge clk_i) begin
        if (w_wtFire) begin
            r_wt[wt_class_i][wt_row_i] <= wt_data_i;
        end
    end

    always_comb begin
        score_o = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            score_o[c*SCORE_W +: SCORE_W] = r_acc[c];
        end
    end
endmodule

// File: tb/tb_bnn_stream_classifier.sv
// Scoreboard bench: stimulus pushes expected results, monitors compare whenever a result is presented.
module tb_bnn_stream_classifier;
    import bnn_pkg::*;

    localparam int W       = DEF_IMG_W;
    localparam int H       = DEF_IMG_H;
    localparam int N       = DEF_N_CLASSES;
    localparam int SW      = DEF_SCORE_W;
    localparam int CW      = $clog2(N);
    localparam int RW      = $clog2(H);
    localparam int LATENCY = 2*N+1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [W-1:0]  rowIn = '0;
    logic          rowValid = 1'b0;
    logic          rowReady;
    logic          wtWe = 1'b0;
    logic [CW-1:0] wtClass = '0;
    logic [RW-1:0] wtRow = '0;
    logic [W-1:0]  wtData = '0;
    logic          wtReady;
    logic [N*SW-1:0] scoreO;
    logic [CW-1:0] classO;
    logic          resValid;
    logic          resReady = 1'b1;

    logic       sRowValid = 1'b0;
    logic [3:0] sRowIn = '0;
    logic       sRowReady;
    logic       sWtWe = 1'b0;
    logic [1:0] sWtClass = '0;
    logic [0:0] sWtRow = '0;
    logic [3:0] sWtData = '0;
    logic       sWtReady;
    logic [11:0] sScoreO;
    logic [1:0] sClassO;
    logic       sResValid;

    bnn_stream_classifier dut (
        .clk_i(clk), .rst_i(rst),
        .row_i(rowIn), .row_valid_i(rowValid), .row_ready_o(rowReady),
        .wt_we_i(wtWe), .wt_class_i(wtClass), .wt_row_i(wtRow), .wt_data_i(wtData),
        .wt_ready_o(wtReady),
        .score_o(scoreO), .class_o(classO),
        .res_valid_o(resValid), .res_ready_i(resReady)
    );

    bnn_stream_classifier #(.IMG_W(4), .IMG_H(2), .N_CLASSES(3)) dutSmall (
        .clk_i(clk), .rst_i(rst),
        .row_i(sRowIn), .row_valid_i(sRowValid), .row_ready_o(sRowReady),
        .wt_we_i(sWtWe), .wt_class_i(sWtClass), .wt_row_i(sWtRow), .wt_data_i(sWtData),
        .wt_ready_o(sWtReady),
        .score_o(sScoreO), .class_o(sClassO),
        .res_valid_o(sResValid), .res_ready_i(1'b1)
    );

    typedef struct {
        logic [N*SW-1:0] score;
        logic [CW-1:0]   cls;
    } exp_t;

    typedef struct {
        logic [11:0] score;
        logic [1:0]  cls;
    } sexp_t;

    exp_t  expQ[$];
    sexp_t sExpQ[$];
    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;
    int lastHsCycle = 0;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Big-instance monitor: first cycle of a result is scored, later stalled cycles must hold.
    exp_t cur;
    bit   haveCur = 0;
    always @(negedge clk) begin
        if (!resValid) begin
            haveCur = 0;
        end else begin
            if (!haveCur) begin
                haveCur = 1;
                checkOutput("pending_expect", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    cur = expQ.pop_front();
                    checkOutput("score", scoreO, cur.score);
                    checkOutput("class", classO, cur.cls);
                    checkOutput("latency", cycle - lastHsCycle, LATENCY);
                end
            end else begin
                checkOutput("hold_score", scoreO, cur.score);
                checkOutput("hold_class", classO, cur.cls);
            end
            checkOutput("row_ready_in_done", rowReady, 0);
        end
    end

    sexp_t sCur;
    bit    sHave = 0;
    always @(negedge clk) begin
        if (!sResValid) begin
            sHave = 0;
        end else if (!sHave) begin
            sHave = 1;
            checkOutput("small_pending", sExpQ.size() > 0, 1);
            if (sExpQ.size() > 0) begin
                sCur = sExpQ.pop_front();
                checkOutput("small_score", sScoreO, sCur.score);
                checkOutput("small_class", sClassO, sCur.cls);
            end
        end
    end

    task automatic pushExpect(input int base, input int hiCls, input int hiVal,
                              input int midCls, input int midVal, input int cls);
        exp_t e;
        for (int c = 0; c < N; c++) begin
            e.score[c*SW +: SW] = SW'((c == hiCls) ? hiVal : (c == midCls) ? midVal : base);
        end
        e.cls = CW'(cls);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [W-1:0] rowData, input bit withWrite,
                                 input int wc, input int wr, input logic [W-1:0] wd);
        int n = 0;
        rowIn = rowData;
        rowValid = 1'b1;
        if (withWrite) begin
            wtWe = 1'b1; wtClass = CW'(wc); wtRow = RW'(wr); wtData = wd;
        end
        @(negedge clk);
        while (!rowReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("row_accept", rowReady, 1);
        lastHsCycle = cycle;
        @(posedge clk); #1;
        rowValid = 1'b0;
        wtWe = 1'b0;
    endtask

    task automatic writeWeight(input int c, input int r, input logic [W-1:0] d);
        wtWe = 1'b1; wtClass = CW'(c); wtRow = RW'(r); wtData = d;
        @(posedge clk); #1;
        wtWe = 1'b0;
    endtask

    task automatic loadWeights(input int onesCls);
        for (int c = 0; c < N; c++)
            for (int r = 0; r < H; r++)
                writeWeight(c, r, (c == onesCls) ? {W{1'b1}} : {W{1'b0}});
    endtask

    task automatic sendRows(input logic [W-1:0] rowData, input int count);
        for (int r = 0; r < count; r++) applyStimulus(rowData, 0, 0, 0, '0);
    endtask

    task automatic waitResult();
        int n = 0;
        while ((expQ.size() != 0 || resValid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("result_drained", expQ.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic sWrite(input int c, input int r, input logic [3:0] d);
        sWtWe = 1'b1; sWtClass = 2'(c); sWtRow = 1'(r); sWtData = d;
        @(posedge clk); #1;
        sWtWe = 1'b0;
    endtask

    task automatic sRow(input logic [3:0] d);
        int n = 0;
        sRowIn = d;
        sRowValid = 1'b1;
        @(negedge clk);
        while (!sRowReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("small_row_accept", sRowReady, 1);
        @(posedge clk); #1;
        sRowValid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_res_valid", resValid, 0);
        checkOutput("reset_class", classO, 0);
        checkOutput("reset_score", scoreO, 0);
        checkOutput("reset_row_ready", rowReady, 1);
        checkOutput("reset_wt_ready", wtReady, 1);
        @(posedge clk); #1;

        // All-zero weights and image: every class ties at 784, lowest index wins.
        loadWeights(-1);
        pushExpect(784, -1, 0, -1, 0, 0);
        sendRows('0, H);
        waitResult();

        // Class 7 all ones against an all-ones image.
        loadWeights(7);
        pushExpect(0, 7, 784, -1, 0, 7);
        sendRows('1, H);
        waitResult();

        // Same image with the consumer stalling for five cycles.
        resReady = 1'b0;
        pushExpect(0, 7, 784, -1, 0, 7);
        sendRows('1, H);
        n = 0;
        while (!resValid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_result_seen", resValid, 1);
        repeat (4) @(negedge clk);
        #1 resReady = 1'b1;
        waitResult();

        // Reset after ten rows discards the partial frame but keeps the weights.
        sendRows('1, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_wt_ready", wtReady, 1);
        checkOutput("midreset_score", scoreO, 0);
        @(posedge clk); #1;
        pushExpect(0, 7, 784, -1, 0, 7);
        sendRows('1, H);
        waitResult();

        // Weight write during ACCUM is dropped.
        pushExpect(0, 7, 784, -1, 0, 7);
        applyStimulus('1, 0, 0, 0, '0);
        checkOutput("wt_ready_accum", wtReady, 0);
        checkOutput("row_ready_accum", rowReady, 0);
        writeWeight(3, 5, '1);
        sendRows('1, H-1);
        waitResult();

        // Same write in IDLE/row 0 lands, plus a row-0 write issued together with the first row.
        writeWeight(3, 5, '1);
        pushExpect(0, 7, 784, 3, 56, 7);
        applyStimulus('1, 1, 3, 0, '1);
        sendRows('1, H-1);
        waitResult();

        // Half-ones pattern gives 14 matches per row for every class: all tie at 392.
        pushExpect(392, -1, 0, -1, 0, 0);
        sendRows(28'hAAAAAAA, H);
        waitResult();

        // Reduced geometry: 4x2 image, three classes.
        sWrite(0, 0, 4'b1010); sWrite(0, 1, 4'b1010);
        sWrite(1, 0, 4'b1111); sWrite(1, 1, 4'b0000);
        sWrite(2, 0, 4'b0000); sWrite(2, 1, 4'b1111);
        sExpQ.push_back('{score: {4'd0, 4'd8, 4'd4}, cls: 2'd1});
        sRow(4'b1111);
        sRow(4'b0000);
        n = 0;
        while ((sExpQ.size() != 0 || sResValid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("small_drained", sExpQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/bnn_stream_classifier.md
Name: bnn_stream_classifier

Overview:
- Sequential, parametrised successor to the combinational BNN top.
- Accepts a binary image one row per handshake and accumulates XNOR-popcount match scores per class against an internal binary weight store.
- Then resolves the argmax and presents scores plus the winning class on a valid/ready result port.
- Sits between the image source (UART/USB register bridge) and the result readout logic.

Parameters:
- IMG_W, 28, pixels per row (bits per row beat).
- IMG_H, 28, rows per image.
- N_CLASSES, 10, number of output classes.
- SCORE_W, $clog2(IMG_W*IMG_H+1), score width; 10 at defaults, so 784 is representable.
- CLS_W, $clog2(N_CLASSES), class index width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- row_i  in  IMG_W  pixel row; bit IMG_W-1 is the leftmost pixel.
- row_valid_i  in  1  row beat valid.
- row_ready_o  out  1  block can accept a row.
- wt_we_i  in  1  weight write strobe.
- wt_class_i  in  CLS_W  weight class index.
- wt_row_i  in  $clog2(IMG_H)  weight row index.
- wt_data_i  in  IMG_W  weight row bits.
- wt_ready_o  out  1  weight write will be accepted this cycle.
- score_o  out  N_CLASSES*SCORE_W  packed scores; class c at [c*SCORE_W +: SCORE_W].
- class_o  out  CLS_W  argmax class.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.

Behaviour:
- Reset state: FSM=IDLE, row counter=0, class counter=0, all score accumulators=0, class_o=0, res_valid_o=0. Weight store is NOT reset; contents are retained across rst_i.
- FSM states are IDLE, ACCUM, ARGMAX and DONE.
  - IDLE: row_ready_o=1. On row_valid_i&&row_ready_o, latch row_i, clear class counter, go to ACCUM.
  - ACCUM: one class per cycle. acc[c] += popcount(~(row ^ W[c][row_cnt])). Popcount is IMG_W wide, zero-extended to SCORE_W with no overflow possible. After class N_CLASSES-1:
    - if row_cnt==IMG_H-1, then row_cnt<=0 and go to ARGMAX;
    - otherwise row_cnt++ and go to IDLE.
    - row_ready_o=0 throughout ACCUM.
  - ARGMAX: one class per cycle, idx 0..N_CLASSES-1. The running best is replaced only when acc[idx] > best (strictly greater), so ties resolve to the lowest index. After the last index, class_o is final; go to DONE.
  - DONE: res_valid_o=1. score_o and class_o hold stable while res_valid_o&&!res_ready_i. On res_ready_i, clear accumulators and go to IDLE in the same edge; res_valid_o drops the next cycle.
- Throughput: one row per N_CLASSES+1 cycles.
- Latency from the last-row handshake to res_valid_o: 2*N_CLASSES+1 cycles, which is 21 at defaults.
- score_o reflects live accumulators during ACCUM/ARGMAX; it is only meaningful when res_valid_o=1.
- Weights:
  - wt_ready_o=1 only in IDLE with row_cnt==0 (between images).
  - A write with wt_we_i&&wt_ready_o updates W[wt_class_i][wt_row_i] at the edge.
  - Writes while wt_ready_o=0 are dropped.
  - wt_class_i>=N_CLASSES is dropped.
- Simultaneous wt_we_i and row_valid_i in IDLE/row 0: both take effect. The row uses the OLD weight value for its ACCUM pass only if the write targets a different row; a write to row 0 is visible to that row (write precedes ACCUM read by one cycle).
- rst_i mid-frame: partial accumulations are discarded and the next row is treated as row 0.
- row_valid_i while row_ready_o=0: ignored; the source must hold it.

Decomposition:
- Package bnn_pkg holds:
  - default IMG_W/IMG_H/N_CLASSES localparams;
  - a score_t typedef (logic [SCORE_W-1:0]);
  - the state enum {IDLE, ACCUM, ARGMAX, DONE}.
- One sub-module, bnn_xnor_popcount (IMG_W-parameterised, purely combinational: row, weight -> match count).

Test Plan:
- All weights 0, all-zero image -> every score 784, class_o=0 (tie to lowest), res_valid_o at 21 cycles after the 28th row handshake.
- Class 7 weights all 1, others 0, all-ones image -> score[7]=784, others 0, class_o=7.
- Same as above but res_ready_i low for 5 cycles -> score_o, class_o and res_valid_o stable for all 5 cycles; row_ready_o=0 throughout; the next image is accepted after the handshake.
- rst_i pulse after 10 rows, then a full 28-row image -> result identical to a clean run, and weights retained.
- Weight write attempted during ACCUM -> dropped (read-back via a scoring run unchanged); the same write in IDLE/row 0 -> takes effect.
- IMG_W=4, IMG_H=2, N_CLASSES=3; weights c0=1010/1010, c1=1111/0000, c2=0000/1111; rows 1111, 0000 -> scores 4, 8, 0; class_o=1.
